// File: rtl/mod_accum_pkg.sv
// Shared constants, state type and modular-add helper for the residue accumulator.
package mod_accum_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 18;
    localparam int unsigned DEF_MODULUS      = 177147;
    localparam int unsigned DEF_MULT_LATENCY = 7;
    localparam int unsigned DEF_CNT_WIDTH    = 16;

    typedef enum logic {
        IDLE,
        ACCUM
    } acc_state_t;

    // Both operands must already be < DEF_MODULUS, so one subtraction suffices.
    function automatic logic [DEF_DATA_WIDTH-1:0] mod_add_once(
        input logic [DEF_DATA_WIDTH-1:0] a,
        input logic [DEF_DATA_WIDTH-1:0] b
    );
        logic [DEF_DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (DEF_DATA_WIDTH + 1)'(DEF_MODULUS)) begin
            s = s - (DEF_DATA_WIDTH + 1)'(DEF_MODULUS);
        end
        return s[DEF_DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/mod_accum_c18_if.sv
// Term input and sum output handshake bundle of the residue accumulator.
interface mod_accum_c18_if
    import mod_accum_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
);

    logic                  in_valid;
    logic                  in_last;
    logic [DATA_WIDTH-1:0] mult_result;
    logic                  out_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0]  out_count;

    modport master (
        output in_valid,
        output in_last,
        output mult_result,
        output out_ready,
        input  out_valid,
        input  out_sum,
        input  out_count
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  mult_result,
        input  out_ready,
        output out_valid,
        output out_sum,
        output out_count
    );

endinterface

// File: rtl/strobe_delay.sv
// Fixed-depth shift register; aligns upstream strobes with the multiplier output.
module strobe_delay #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mod_accum_c18.sv
// Modular dot-product accumulator behind the constant multiplier, with a one-entry
// ready/valid result buffer and sticky range/overrun flags.
module mod_accum_c18
    import mod_accum_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned MODULUS      = DEF_MODULUS,
    parameter int unsigned MULT_LATENCY = DEF_MULT_LATENCY,
    parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    mod_accum_c18_if.slave   bus,
    input  logic             err_clr,
    output logic             range_err,
    output logic             overrun_err
);

    localparam logic [DATA_WIDTH-1:0] ModVal = DATA_WIDTH'(MODULUS);

    acc_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_sum_q, out_sum_d;
    logic [CNT_WIDTH-1:0]  out_count_q, out_count_d;
    logic                  range_err_q, range_err_d;
    logic                  overrun_err_q, overrun_err_d;

    logic [1:0]            strobe_a;
    logic                  v_a, l_a;
    logic                  term_oor;
    logic [DATA_WIDTH-1:0] term_x;
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] sum_s;
    logic [CNT_WIDTH-1:0]  cnt_n;
    logic                  complete;

    // A last strobe without a valid must never reach the aligned domain.
    strobe_delay #(
        .WIDTH(2),
        .DEPTH(MULT_LATENCY)
    ) u_strobe_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  ({bus.in_valid, bus.in_valid & bus.in_last}),
        .q_o  (strobe_a)
    );

    assign v_a = strobe_a[1];
    assign l_a = strobe_a[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (v_a) begin
            state_d = l_a ? IDLE : ACCUM;
        end
    end

    always_comb begin
        term_oor = (bus.mult_result >= ModVal);
        term_x   = term_oor ? '0 : bus.mult_result;
        base     = (state_q == ACCUM) ? acc_q : '0;
        sum_s    = mod_add_once(base, term_x);
        if (state_q == IDLE) begin
            cnt_n = CNT_WIDTH'(1);
        end else if (cnt_q == '1) begin
            cnt_n = cnt_q;
        end else begin
            cnt_n = cnt_q + 1'b1;
        end
        complete = v_a & l_a;

        acc_d = acc_q;
        cnt_d = cnt_q;
        if (v_a && !l_a) begin
            acc_d = sum_s;
            cnt_d = cnt_n;
        end

        out_valid_d   = out_valid_q;
        out_sum_d     = out_sum_q;
        out_count_d   = out_count_q;
        overrun_err_d = overrun_err_q & ~err_clr;
        if (complete) begin
            if (!out_valid_q || bus.out_ready) begin
                out_valid_d = 1'b1;
                out_sum_d   = sum_s;
                out_count_d = cnt_n;
            end else begin
                overrun_err_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        range_err_d = (v_a & term_oor) | (range_err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q         <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_sum_q     <= '0;
            out_count_q   <= '0;
            range_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_sum_q     <= out_sum_d;
            out_count_q   <= out_count_d;
            range_err_q   <= range_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign range_err     = range_err_q;
    assign overrun_err   = overrun_err_q;

endmodule

// File: tb/tb_mod_accum_c18.sv
// Bench for mod_accum_c18: directed cases plus random traffic against a queue-based model.
module tb_mod_accum_c18;

    localparam int DW  = 18;
    localparam int CW  = 16;
    localparam int LAT = 7;
    localparam int M   = 177147;

    typedef struct {
        int due;
        bit last;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    logic range_err, overrun_err;
    logic [DW-1:0] term_drv = '0;
    logic [DW-1:0] mpipe [LAT];

    int errors = 0;
    int checks = 0;
    int ecount = 0;
    bit rdy = 1'b1;
    bit clr = 1'b0;

    ev_t evq[$];
    bit  m_busy, m_valid, m_rerr, m_oerr;
    int  m_sum, m_cnt, m_osum, m_ocnt;

    always #5 clk = ~clk;

    mod_accum_c18_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    mod_accum_c18 #(
        .DATA_WIDTH  (DW),
        .MODULUS     (M),
        .MULT_LATENCY(LAT),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .err_clr    (err_clr),
        .range_err  (range_err),
        .overrun_err(overrun_err)
    );

    // Stand-in multiplier: fixed latency, never reset.
    always @(posedge clk) begin
        mpipe[0] <= term_drv;
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mult_result = mpipe[LAT-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check_eq("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check_eq("out_sum", 32'(bus.out_sum), 32'(m_osum));
        check_eq("out_count", 32'(bus.out_count), 32'(m_ocnt));
        check_eq("range_err", 32'(range_err), 32'(m_rerr));
        check_eq("overrun_err", 32'(overrun_err), 32'(m_oerr));
    endtask

    task automatic model_clear();
        evq.delete();
        m_busy = 0; m_valid = 0; m_rerr = 0; m_oerr = 0;
        m_sum = 0; m_cnt = 0; m_osum = 0; m_ocnt = 0;
    endtask

    // Each term takes effect LAT edges after it is presented.
    task automatic model_edge(input bit v, input bit l, input int val);
        bit complete, rset, oset;
        int s, n, x;
        ev_t e;
        complete = 0; rset = 0; oset = 0; s = 0; n = 0;
        if (evq.size() > 0 && evq[0].due == ecount) begin
            e = evq.pop_front();
            rset = (e.val >= M);
            x = rset ? 0 : e.val;
            s = m_busy ? (m_sum + x) % M : x;
            n = m_busy ? ((m_cnt < 65535) ? m_cnt + 1 : 65535) : 1;
            if (e.last) begin
                complete = 1;
                m_busy = 0;
            end else begin
                m_busy = 1;
                m_sum = s;
                m_cnt = n;
            end
        end
        if (complete) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_osum = s; m_ocnt = n;
            end else begin
                oset = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_rerr = rset | (m_rerr & !clr);
        m_oerr = oset | (m_oerr & !clr);
        if (v) evq.push_back('{due: ecount + LAT, last: l, val: val});
    endtask

    task automatic step(input bit v, input bit l, input int val);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_last   = l;
        term_drv      = v ? DW'(val) : DW'($urandom_range(0, 262143));
        bus.out_ready = rdy;
        err_clr       = clr;
        @(posedge clk);
        ecount++;
        model_edge(v, l, val);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(bus.out_valid), 0);
        check_eq({tag, "_sum"}, 32'(bus.out_sum), 0);
        check_eq({tag, "_count"}, 32'(bus.out_count), 0);
        check_eq({tag, "_rerr"}, 32'(range_err), 0);
        check_eq({tag, "_oerr"}, 32'(overrun_err), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        #1;
        check_zero("rst_mid");
        repeat (3) @(posedge clk);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0; bus.in_last = 0; bus.out_ready = 1;
        model_clear();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Two-term wrap with latency check
        rdy = 0;
        step(1, 0, 100000);
        step(1, 1, 100000);
        idle(6);
        check_eq("wrap_lat_early", 32'(bus.out_valid), 0);
        idle(1);
        check_eq("wrap_lat_valid", 32'(bus.out_valid), 1);
        check_eq("wrap_sum", 32'(bus.out_sum), 22853);
        check_eq("wrap_count", 32'(bus.out_count), 2);

        // Edge wrap then back-to-back single-term sum
        rdy = 1;
        idle(1);
        step(1, 0, 177146);
        step(1, 1, 1);
        step(1, 1, 5);
        idle(6);
        check_eq("edge_valid", 32'(bus.out_valid), 1);
        check_eq("edge_sum", 32'(bus.out_sum), 0);
        idle(1);
        check_eq("single_valid", 32'(bus.out_valid), 1);
        check_eq("single_sum", 32'(bus.out_sum), 5);
        check_eq("single_count", 32'(bus.out_count), 1);
        idle(1);
        check_eq("single_drain", 32'(bus.out_valid), 0);

        // Out-of-range term
        rdy = 0;
        step(1, 0, 177147);
        step(1, 1, 10);
        idle(7);
        check_eq("range_flag", 32'(range_err), 1);
        check_eq("range_sum", 32'(bus.out_sum), 10);
        check_eq("range_count", 32'(bus.out_count), 2);
        clr = 1;
        idle(1);
        clr = 0;
        check_eq("range_clr", 32'(range_err), 0);

        // Backpressure: second completion dropped
        rdy = 1;
        idle(1);
        rdy = 0;
        step(1, 1, 7);
        step(1, 1, 9);
        idle(7);
        check_eq("bp_sum", 32'(bus.out_sum), 7);
        check_eq("bp_overrun", 32'(overrun_err), 1);
        clr = 1;
        idle(1);
        clr = 0;
        check_eq("bp_clr", 32'(overrun_err), 0);
        rdy = 1;
        idle(1);

        // Backpressure released on the second completion
        rdy = 0;
        step(1, 1, 7);
        step(1, 1, 9);
        idle(6);
        check_eq("bp2_first", 32'(bus.out_sum), 7);
        rdy = 1;
        idle(1);
        check_eq("bp2_sum", 32'(bus.out_sum), 9);
        check_eq("bp2_valid", 32'(bus.out_valid), 1);
        check_eq("bp2_overrun", 32'(overrun_err), 0);
        idle(1);

        // Reset with a held result and terms in flight
        rdy = 0;
        step(1, 1, 50);
        idle(7);
        check_eq("pre_rst_valid", 32'(bus.out_valid), 1);
        step(1, 0, 1000);
        step(1, 0, 2000);
        idle(2);
        do_reset();
        step(1, 0, 3);
        step(1, 1, 4);
        idle(7);
        check_eq("post_rst_sum", 32'(bus.out_sum), 7);
        check_eq("post_rst_count", 32'(bus.out_count), 2);
        check_eq("post_rst_valid", 32'(bus.out_valid), 1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            int val;
            bit v, l;
            v   = ($urandom_range(0, 9) < 7);
            l   = ($urandom_range(0, 9) < 3);
            val = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 262143))
                                              : int'($urandom_range(0, M - 1));
            rdy = $urandom_range(0, 1);
            clr = ($urandom_range(0, 19) == 0);
            step(v, l, val);
        end
        clr = 0;
        rdy = 1;
        idle(LAT + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_accum_c18.md
# mod_accum_c18

Residue-channel modular accumulator that sits directly downstream of the 18-bit constant modular multiplier. It forms dot-product partial sums modulo MODULUS and is the next stage of the TPU residue datapath. The multiplier has no valid signal, so this block delays the upstream valid/last strobes by the multiplier's fixed latency to align them with `mult_result`. It accumulates terms modulo MODULUS and presents each completed sum through a one-entry ready/valid output buffer.

## Interface
- `DATA_WIDTH`, 18: width of residue data.
- `MODULUS`, 177147: channel modulus (3^11); must be < 2^DATA_WIDTH.
- `MULT_LATENCY`, 7: clock edges from multiplier input register to `mult_result`.
- `CNT_WIDTH`, 16: width of the term counter.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: term presented to multiplier input this cycle.
- `in_last` in 1: qualifies `in_valid`; final term of the current sum.
- `mult_result` in DATA_WIDTH: multiplier output.
- `out_ready` in 1: consumer accepts `out_sum`.
- `err_clr` in 1: clears sticky error flags.
- `out_valid` out 1: `out_sum`/`out_count` valid.
- `out_sum` out DATA_WIDTH: completed sum mod MODULUS.
- `out_count` out CNT_WIDTH: number of terms in the sum, saturating.
- `range_err` out 1: sticky; a term ≥ MODULUS was seen.
- `overrun_err` out 1: sticky; a completed sum was dropped.

## Operation
- **Strobe delay line**
  - Delays `in_valid` and `in_last` by MULT_LATENCY stages, giving `v_a` and `l_a`.
  - All stages reset to 0.
  - `mult_result` is sampled only when `v_a`=1.
- **State machine**
  - IDLE: no partial sum.
  - ACCUM: partial sum held in `acc` (DATA_WIDTH) and `cnt` (CNT_WIDTH).
  - IDLE, `v_a`, !`l_a` → ACCUM.
  - ACCUM, `v_a`, `l_a` → IDLE.
  - IDLE, `v_a`, `l_a` → IDLE: single-term sum.
  - Otherwise hold state.
- **Term sanitising**
  - If `mult_result` ≥ MODULUS, the term is x = 0 and `range_err` is set.
  - Otherwise x = `mult_result`.
  - The term is still counted.
- **Add**
  - base = 0 in IDLE, `acc` in ACCUM.
  - s = base + x, computed at DATA_WIDTH+1 bits.
  - If s ≥ MODULUS then s = s − MODULUS.
  - The result is always < MODULUS.
- **Count**
  - n = (IDLE ? 1 : `cnt`+1).
  - Saturates at 2^CNT_WIDTH−1.
- **On `v_a` & !`l_a`:** `acc`←s, `cnt`←n.
- **On `v_a` & `l_a` (completion):** sum s and count n go to the output buffer; `acc` and `cnt` are not updated.
- **Output buffer**
  - Empty, or `out_ready`=1 this cycle: completion loads the buffer and `out_valid`←1.
  - `out_valid`=1 & `out_ready`=0 at completion: new result dropped, buffer unchanged, `overrun_err`←1.
  - `out_ready` & `out_valid` with no completion: `out_valid`←0.
- **Sticky flags**
  - Cleared by `err_clr`.
  - If a set event coincides with `err_clr`, the set wins.
- **Reset values:** `out_valid`, `out_sum`, `out_count`, `range_err`, `overrun_err`, `acc`, `cnt`, and state all 0 / IDLE.

## Timing
- A term with `in_valid` sampled at edge t is aligned (`v_a`) in the cycle after edge t+MULT_LATENCY−1, matching `mult_result` for that term.
- `out_valid` rises after edge t+MULT_LATENCY for the `in_last` term; latency from last term input to output is MULT_LATENCY+1 edges.
- Back-to-back terms and back-to-back sums are sustained at 1 term/cycle with no bubbles.
- A completion may coincide with acceptance of the previous result (`out_ready`=1): the buffer reloads and `out_valid` stays 1.
- **Reset mid-operation**
  - Partial sums and in-flight strobes are discarded.
  - Stale `mult_result` values after reset are ignored because the delay line is cleared.
  - The multiplier pipeline itself is not reset.
- `in_last` without `in_valid` is ignored.

## Structure
- Shared package `mod_accum_pkg`:
  - DATA_WIDTH, MODULUS, and MULT_LATENCY defaults;
  - state typedef `acc_state_t` {IDLE, ACCUM};
  - function `mod_add_once(a, b)`, returning a conditional-subtract sum.
- One sub-module: `strobe_delay` (WIDTH=2, DEPTH=MULT_LATENCY). It is a shift register with async active-low reset to 0.
- Everything else is flat in `mod_accum_c18`.

## Test plan
- **Two-term wrap:** terms 100000, 100000 (last on the 2nd) → `out_sum`=22853, `out_count`=2, `out_valid` MULT_LATENCY+1 edges after the last input.
- **Edge wrap then single-term sum:**
  - terms 177146, 1 → `out_sum`=0.
  - then a single-term sum of 5 with `in_last` on the same cycle → `out_sum`=5, `out_count`=1, back-to-back with no bubble.
- **Range error:** `mult_result`=177147 forced on an aligned term, then 10 last → `range_err`=1, `out_sum`=10, `out_count`=2; `err_clr` then clears the flag.
- **Backpressure:**
  - `out_ready`=0; complete sums 7, then 9 → `out_sum` stays 7, `overrun_err`=1.
  - Repeat with `out_ready`=1 on the 2nd completion cycle → `out_sum`=9, `out_valid` stays 1, no error.
- **Reset mid-operation:**
  - assert `rst_n`=0 mid-sum with terms in flight → all outputs 0.
  - a new sum 3, 4 after release → 7; no stale contribution.
